// File: rtl/snake_pkg.sv
// snake_pkg: shared constants for the snake host register stage.
//   - EPP register addresses (ADDR_ID .. ADDR_SCORE)
//   - head direction encoding (DIR_UP .. DIR_LEFT)
//   - CTRL and STATUS register bit positions
package snake_pkg;

   localparam logic [7:0] ADDR_ID     = 8'h00;
   localparam logic [7:0] ADDR_CTRL   = 8'h01;
   localparam logic [7:0] ADDR_DIR    = 8'h02;
   localparam logic [7:0] ADDR_STATUS = 8'h03;
   localparam logic [7:0] ADDR_SPEED  = 8'h04;
   localparam logic [7:0] ADDR_SCORE  = 8'h05;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_RIGHT = 2'd1;
   localparam logic [1:0] DIR_DOWN  = 2'd2;
   localparam logic [1:0] DIR_LEFT  = 2'd3;

   localparam int unsigned CTRL_RUN      = 0;
   localparam int unsigned CTRL_PAUSE    = 1;
   localparam int unsigned CTRL_SOFT_RST = 2;

   localparam int unsigned STATUS_GAME_OVER = 6;
   localparam int unsigned STATUS_OVF       = 7;

endpackage

// File: rtl/snake_dir_fifo.sv
// snake_dir_fifo: synchronous FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear (overrides push/pop)
//   push/wdata : write request and data; accepted when not full or when
//                a pop happens in the same cycle
//   pop        : remove head entry; ignored while empty
//   rdata      : head entry (0 while empty)
//   count      : number of stored entries
//   full/empty : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module snake_dir_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;
   assign rdata = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      pop_ok   = pop && !empty;
      // a pop frees the slot the push needs, so full+pop+push is accepted
      push_ok  = push && (!full || pop_ok);
      if (flush) begin
         pop_ok   = 1'b0;
         push_ok  = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
         else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: the head is masked while empty
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/snake_host_regs.sv
// snake_host_regs: host register/command stage between the EPP slave and
// the snake game core.
//   clk, rst_n               : clock, asynchronous active-low reset
//   epp_addr/wdata/wr/rd     : EPP register access (single-cycle strobes)
//   epp_rdata, epp_rdata_rdy : registered read data and its valid pulse
//   cmd_valid/cmd_dir/cmd_pop: direction command FIFO towards the game
//   game_tick                : one-cycle step pulse every (SPEED+1)*PRESC_DIV
//   game_rst                 : one-cycle soft-reset pulse to the game
//   game_over, score         : status inputs from the game
// Optional build macro SNAKE_REV_FILTER_EN: drop DIR writes that would
// reverse the head by 180 degrees relative to last_dir.
module snake_host_regs
   import snake_pkg::*;
#(
   parameter int unsigned PRESC_DIV  = 250000,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  ID_VALUE   = 8'h5A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] epp_addr,
   input  logic [7:0] epp_wdata,
   input  logic       epp_wr,
   input  logic       epp_rd,
   output logic [7:0] epp_rdata,
   output logic       epp_rdata_rdy,
   output logic       cmd_valid,
   output logic [1:0] cmd_dir,
   input  logic       cmd_pop,
   output logic       game_tick,
   output logic       game_rst,
   input  logic       game_over,
   input  logic [7:0] score
);

   localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

   logic          run_q, run_d;
   logic          pause_q, pause_d;
   logic [7:0]    speed_q, speed_d;
   logic          ovf_q, ovf_d;
   logic [1:0]    last_dir_q, last_dir_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    step_q, step_d;
   logic          tick_q, tick_d;
   logic          game_rst_q, game_rst_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          rdy_q, rdy_d;

   logic          wr_ctrl, wr_dir, wr_status, wr_speed;
   logic          soft_rst, dir_rev, fifo_push, fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [7:0]    rd_mux;

   assign wr_ctrl   = epp_wr && (epp_addr == ADDR_CTRL);
   assign wr_dir    = epp_wr && (epp_addr == ADDR_DIR);
   assign wr_status = epp_wr && (epp_addr == ADDR_STATUS);
   assign wr_speed  = epp_wr && (epp_addr == ADDR_SPEED);
   assign soft_rst  = wr_ctrl && epp_wdata[CTRL_SOFT_RST];

`ifdef SNAKE_REV_FILTER_EN
   // opposite direction differs only in bit 1 (up<->down, right<->left)
   assign dir_rev = (epp_wdata[1:0] == (last_dir_q ^ DIR_DOWN));
`else
   assign dir_rev = 1'b0;
`endif

   assign fifo_push = wr_dir && !dir_rev;

   snake_dir_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(2)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (soft_rst),
      .push  (fifo_push),
      .wdata (epp_wdata[1:0]),
      .pop   (cmd_pop),
      .rdata (cmd_dir),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cmd_valid     = !fifo_empty;
   assign epp_rdata     = rdata_q;
   assign epp_rdata_rdy = rdy_q;
   assign game_tick     = tick_q;
   assign game_rst      = game_rst_q;

   // read mux uses only current (pre-write) state
   always_comb begin
      rd_mux = '0;
      case (epp_addr)
         ADDR_ID:     rd_mux = ID_VALUE;
         ADDR_CTRL: begin
            rd_mux[CTRL_RUN]   = run_q;
            rd_mux[CTRL_PAUSE] = pause_q;
         end
         ADDR_DIR:    rd_mux[1:0] = last_dir_q;
         ADDR_STATUS: begin
            rd_mux[2:0]              = 3'(fifo_count);
            rd_mux[STATUS_GAME_OVER] = game_over;
            rd_mux[STATUS_OVF]       = ovf_q;
         end
         ADDR_SPEED:  rd_mux = speed_q;
         ADDR_SCORE:  rd_mux = score;
         default:     rd_mux = '0;
      endcase
   end

   always_comb begin
      run_d      = run_q;
      pause_d    = pause_q;
      speed_d    = speed_q;
      ovf_d      = ovf_q;
      last_dir_d = last_dir_q;
      presc_d    = presc_q;
      step_d     = step_q;
      tick_d     = 1'b0;
      game_rst_d = 1'b0;
      rdata_d    = rdata_q;
      rdy_d      = 1'b0;

      if (epp_rd) begin
         rdata_d = rd_mux;
         rdy_d   = 1'b1;
      end

      if (wr_ctrl) begin
         run_d   = epp_wdata[CTRL_RUN];
         pause_d = epp_wdata[CTRL_PAUSE];
      end
      if (wr_speed) speed_d = epp_wdata;
      if (wr_status && epp_wdata[STATUS_OVF]) ovf_d = 1'b0;

      if (fifo_push) begin
         if (!fifo_full || cmd_pop) last_dir_d = epp_wdata[1:0];
         else                       ovf_d      = 1'b1;
      end

      if (!run_q) begin
         presc_d = '0;
         step_d  = '0;
      end else if (!pause_q) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            if (step_q == speed_q) begin
               step_d = '0;
               tick_d = 1'b1;
            end else begin
               step_d = step_q + 8'd1;
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
      if (wr_speed) step_d = '0;

      if (soft_rst) begin
         game_rst_d = 1'b1;
         ovf_d      = 1'b0;
         last_dir_d = DIR_RIGHT;
         presc_d    = '0;
         step_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= 1'b0;
         pause_q    <= 1'b0;
         speed_q    <= 8'd7;
         ovf_q      <= 1'b0;
         last_dir_q <= DIR_RIGHT;
         presc_q    <= '0;
         step_q     <= '0;
         tick_q     <= 1'b0;
         game_rst_q <= 1'b0;
         rdata_q    <= '0;
         rdy_q      <= 1'b0;
      end else begin
         run_q      <= run_d;
         pause_q    <= pause_d;
         speed_q    <= speed_d;
         ovf_q      <= ovf_d;
         last_dir_q <= last_dir_d;
         presc_q    <= presc_d;
         step_q     <= step_d;
         tick_q     <= tick_d;
         game_rst_q <= game_rst_d;
         rdata_q    <= rdata_d;
         rdy_q      <= rdy_d;
      end
   end

endmodule
